// File: rtl/rca8_seq_ctrl.sv
// rca8_seq_ctrl: adds two NBYTES-wide operands one byte per cycle through a
// single shared 8-bit ripple-carry adder, with valid/ready handshakes on both
// the operation input and the result output.

// rca8: plain 8-bit ripple-carry adder built from a chain of full adders.
module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Ripple the carry bit by bit from the LSB up to the carry-out.
  always_comb begin
    logic [8:0] c;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

module rca8_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [CW+2:0]  byte_base;
  logic [7:0]     rca_a;
  logic [7:0]     rca_b;
  logic [7:0]     rca_sum;
  logic           rca_cout;

  // Steer the byte selected by the counter into the shared adder.
  always_comb begin
    byte_base = {cnt_q, 3'b000};
    rca_a     = a_q[byte_base +: 8];
    rca_b     = b_q[byte_base +: 8];
  end

  rca8 u_rca8 (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // Next-state and datapath update: accept in IDLE, one byte per cycle in RUN,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[byte_base +: 8] = rca_sum;
        carry_d               = rca_cout;
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = '0;
          cout_d  = rca_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs are decoded straight from the state register
  // so that they take their reset values as soon as reset asserts.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_sum   = sum_q;
    out_cout  = cout_q;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rca8_seq_ctrl.sv
// tb_rca8_seq_ctrl: directed operations against rca8_seq_ctrl, checked every
// cycle against an arithmetic reference model and pinned with literal results.
module tb_rca8_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an accepted operation becomes visible NBYTES edges later
  // as plain A+B+cin, then waits for the consumer.
  int            m_run_left;
  logic          m_done;
  logic [W:0]    m_pend;
  logic [W-1:0]  m_sum;
  logic          m_cout;
  logic          m_idle;

  rca8_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model update on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run_left <= 0;
      m_done     <= 1'b0;
      m_pend     <= '0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_run_left != 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_pend[W-1:0];
        m_cout <= m_pend[W];
      end
    end else if (in_valid) begin
      m_pend     <= {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      m_run_left <= NBYTES;
    end
  end

  assign m_idle = (m_run_left == 0) && !m_done;

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_in_ready", {63'd0, in_ready}, {63'd0, m_idle});
      checkOutput("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_done});
      checkOutput("cyc_busy", {63'd0, busy}, {63'd0, !m_idle});
      if (m_run_left == 0) begin
        checkOutput("cyc_out_sum", {32'd0, out_sum}, {32'd0, m_sum});
        checkOutput("cyc_out_cout", {63'd0, out_cout}, {63'd0, m_cout});
      end
    end
  end

  // One full operation: accept, scramble inputs during RUN, wait for the
  // result, optionally hold backpressure with in_valid high, then consume.
  task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                               input int hold_cycles);
    int cycles;
    @(negedge clk);
    checkOutput({name, "_ready_before"}, {63'd0, in_ready}, 64'd1);
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
    in_valid = (hold_cycles > 0);
    cycles   = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({name, "_latency"}, 64'(cycles), 64'(NBYTES));
    checkOutput({name, "_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
    checkOutput({name, "_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
    checkOutput({name, "_model_sum"}, {32'd0, m_sum}, {32'd0, exp_sum});
    checkOutput({name, "_model_cout"}, {63'd0, m_cout}, {63'd0, exp_cout});
    for (int i = 0; i < hold_cycles; i++) begin
      in_a = in_a + 32'h0101_0101;
      @(posedge clk);
      #1;
      checkOutput({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      checkOutput({name, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      checkOutput({name, "_hold_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
      checkOutput({name, "_hold_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({name, "_post_valid"}, {63'd0, out_valid}, 64'd0);
    checkOutput({name, "_post_ready"}, {63'd0, in_ready}, 64'd1);
    checkOutput({name, "_post_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({name, "_post_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
  endtask

  // Reset asserted two cycles into RUN must clear everything immediately.
  task automatic abortByReset();
    @(negedge clk);
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("abort_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_out_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("abort_out_cout", {63'd0, out_cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed test sequence.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_out_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("reset_out_cout", {63'd0, out_cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic carry-through and mixed operands");
    applyStimulus("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0);
    applyStimulus("mixed",   32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 0);
    applyStimulus("midcarry",32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 0);
    applyStimulus("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);

    $display("[TB] backpressure with in_valid held high");
    applyStimulus("backpr",  32'hA5A5_0F0F, 32'h5A5A_F0F0, 1'b1, 32'h0000_0000, 1'b1, 5);

    $display("[TB] operand change during RUN");
    applyStimulus("latched", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0);

    $display("[TB] reset abort and recovery");
    applyStimulus("prereset",32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 0);
    abortByReset();
    applyStimulus("recover", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 0);

    $display("[TB] back-to-back carry isolation");
    applyStimulus("b2b_a",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 0);
    applyStimulus("b2b_b",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rca8_seq_ctrl.md
RCA8_SEQ_CTRL -- requirements
Module: rca8_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, meaning operand width in bytes (legal 2..8); W = 8*NBYTES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, requester presents an operation.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have port in_a, input, W, operand A.
REQ-007 The block SHALL have port in_b, input, W, operand B.
REQ-008 The block SHALL have port in_cin, input, 1, carry-in to byte 0.
REQ-009 The block SHALL have port out_valid, output, 1, result available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, W, A+B+cin modulo 2^W.
REQ-012 The block SHALL have port out_cout, output, 1, carry out of the MSB byte.
REQ-013 The block SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-014 The block SHALL instantiate exactly one RCA8 and time-share it across all bytes; no other adder logic on the sum path.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-016 An operation SHALL be accepted on an edge where in_valid && in_ready; in_a, in_b latched into internal registers, carry register loaded with in_cin, byte counter cleared to 0, state -> RUN.
REQ-017 In RUN, each cycle with counter k, RCA8 SHALL add byte k of latched A and B plus the carry register; the edge writes sum into result byte k and RCA8 cout into the carry register.
REQ-018 The counter SHALL increment 0..NBYTES-1; on the edge processing byte NBYTES-1 the state SHALL go to DONE, the counter returns to 0, and out_cout takes the final carry.
REQ-019 Latency: if accepted at edge T, out_valid SHALL be high exactly after edge T+NBYTES.
REQ-020 In DONE, out_sum and out_cout SHALL hold stable while out_ready is low (indefinite backpressure).
REQ-021 On an edge with out_valid && out_ready, state SHALL go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-022 Changes on in_a, in_b, in_cin, in_valid during RUN or DONE SHALL have no effect.
REQ-023 Each accepted operation SHALL re-initialise the carry register from in_cin; no carry leaks between operations.
REQ-024 out_sum and out_cout SHALL retain the last result in IDLE until the next result is written.

Reset
REQ-025 While rst_n = 0: state IDLE, in_ready = 1, out_valid = 0, busy = 0, out_sum = 0, out_cout = 0, counter = 0, carry register = 0, operand registers = 0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation immediately with no result emitted; the first operation after release SHALL compute correctly.

Verification (NBYTES = 4)
REQ-027 a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid high 4 cycles after accept.
REQ-028 a=0x12345678, b=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0.
REQ-029 Result ready, out_ready held low 5 cycles with in_valid=1 -> out_valid, out_sum, out_cout constant, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-030 Accept, then drive rst_n low after 2 RUN cycles -> all outputs at reset values asynchronously; after release, a=0x00000005, b=0x00000003, cin=0 -> 0x00000008, cout=0.
REQ-031 Accept a=0x000000FF, b=0x00000001, then change in_a to 0xFFFFFFFF during RUN -> out_sum=0x00000100 (latched operands used).
REQ-032 Back-to-back: 0x80000000+0x80000000, cin=0 -> 0x00000000, cout=1; then 0x00000000+0x00000000, cin=1 -> 0x00000001, cout=0.
